vec_op_sequencer: RTL and testbench
===================================

Name: vec_op_sequencer

Overview:
- Single-issue controller that takes vector instructions from the host interface (Python HAL side) and sequences the 16-entry vector register bank and the external vector ALU.
- Per instruction: decodes, drives the bank read selects/enables, starts the ALU and waits for it, writes the result back, or returns register contents to the host.
- Sits between the host command path and the vec_reg_bank / vec_alu pair.

Parameters:
- BITS, 8, width of one vector element.
- N, 2, elements per vector.
- TIMEOUT, 64, maximum cycles to wait for alu_done before aborting.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_valid  in  1  host instruction valid.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  4  opcode.
- instr_dst  in  4  destination register.
- instr_src_a  in  4  source register A.
- instr_src_b  in  4  source register B.
- instr_data  in  BITS x N  LOAD payload, unpacked [N-1:0].
- result_valid  out  1  STORE data valid.
- result_ready  in  1  host accepts STORE data.
- result_data  out  BITS x N  STORE payload.
- rb_data_in  out  BITS x N  bank write data.
- rb_in_sel  out  4  bank write select.
- rb_write  out  1  bank write strobe.
- rb_out_sel_a  out  4  bank read select A.
- rb_out_sel_b  out  4  bank read select B.
- rb_out_en_a  out  1  bank read enable A.
- rb_out_en_b  out  1  bank read enable B.
- rb_out_a  in  BITS x N  bank read data A.
- rb_out_b  in  BITS x N  bank read data B.
- alu_op  out  4  ALU operation, equal to the opcode.
- alu_start  out  1  one-cycle ALU start pulse.
- alu_done  in  1  ALU result valid.
- alu_result  in  BITS x N  ALU result.
- done  out  1  one-cycle pulse when an instruction retires.
- busy  out  1  state != IDLE.
- err_illegal  out  1  sticky: illegal opcode seen.
- err_timeout  out  1  sticky: ALU timeout occurred.
- err_clr  in  1  clears both sticky error flags.
- instr_count  out  16  retired instructions, wraps at 0xFFFF->0.

Behaviour:
- Opcodes:
  - 0 NOP, 1 LOAD, 2 STORE, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 MOV.
  - 9-15 are illegal: the instruction is consumed, err_illegal is set, no bank write occurs, done does not pulse and instr_count does not increment.
- Reset, asynchronous: state=IDLE and every output is 0, including instr_ready. Captured instruction, timeout counter and instr_count are cleared. A reset mid-instruction drops the instruction and rb_write falls immediately, so no partial write occurs.
- Handshake: instr_ready = (state==IDLE) && !rst. The instruction is captured on the cycle where instr_valid && instr_ready. Inputs are ignored while busy.
- State machine: states are IDLE, READ, EXEC, WRITE, OUT.
  - IDLE:
    - On accept, NOP goes straight to retire (done next cycle, stays IDLE).
    - LOAD -> WRITE.
    - STORE, MOV and ALU ops -> READ.
  - READ (1 cycle):
    - rb_out_sel_a=src_a and rb_out_en_a=1; for ALU ops also rb_out_sel_b=src_b and rb_out_en_b=1.
    - At the end of the cycle, rb_out_a is registered (for MOV/STORE).
    - Next state: ALU ops -> EXEC, MOV -> WRITE, STORE -> OUT.
  - EXEC:
    - Read selects and enables are held; alu_op is held.
    - alu_start=1 on the first EXEC cycle only.
    - When alu_done=1, alu_result is registered and the FSM goes to WRITE.
    - The timeout counter counts EXEC cycles. If TIMEOUT cycles pass without alu_done, err_timeout is set, the FSM goes to IDLE and there is no write or retire.
  - WRITE (1 cycle): rb_in_sel=dst, rb_data_in=registered data (LOAD payload, MOV copy or ALU result), rb_write=1. Then IDLE and retire.
  - OUT: result_valid=1 and result_data is held stable until result_ready. On the handshake the FSM goes to IDLE and retires. result_ready is ignored in other states.
- Retire: done pulses for one cycle and instr_count increments.
- Latency from accept cycle to done:
  - NOP: 1.
  - LOAD: 2.
  - MOV: 3.
  - STORE: 2 + host wait.
  - ALU op: 3 + ALU latency.
- Error flags: if err_clr and a new error event occur in the same cycle, the new event wins. The flags are otherwise only cleared by rst.
- Hazards: dst may equal a source. Execution is single-issue, so there are no hazards.
- Outside READ and EXEC, the read enables are 0. Outside WRITE, rb_write is 0.

Decomposition:
- vec_pkg holds:
  - opcode enum vec_op_t (4-bit) with the values above;
  - state enum seq_state_t;
  - REG_SEL_W=4;
  - NUM_VREGS=16.
- No sub-module is needed. The timeout counter and instr_count stay inline. vec_reg_bank and vec_alu are instantiated by the parent.

Test Plan:
- Reset, then LOAD dst=0 data {0x3C,0x0F}: rb_write is high for exactly 1 cycle with rb_in_sel=0 and data {0x3C,0x0F}; done pulses 2 cycles after accept; instr_count=1.
- LOAD r1={0x7E,0xFF}, r2={0x00,0x01} (model bank), then ADD dst=3 a=1 b=2 with the ALU done 2 cycles after start: alu_start pulses once, alu_op=3, then rb_write to r3 with {0x7E,0x00}.
- STORE src_a=3 with result_ready low for 5 cycles: result_valid and data stay stable and instr_ready stays low; retire on the handshake.
- ALU op with alu_done never asserted and TIMEOUT=64: err_timeout=1 after 64 EXEC cycles; no rb_write; instr_count unchanged; then err_clr clears the flag.
- Opcode 12: instruction consumed, err_illegal=1, no write, no done; the following NOP retires normally.
- rst asserted mid-EXEC: all outputs 0 immediately, no write; after release, a LOAD executes correctly.

Source files
------------

// File: rtl/vec_pkg.sv
// -----------------------------------------------------------------------------
// vec_pkg
// Shared types and constants for the vector instruction sequencer:
//   vec_op_t     - 4-bit opcode encoding (9..15 are illegal)
//   seq_state_t  - sequencer FSM states
//   REG_SEL_W    - width of a vector register select
//   NUM_VREGS    - number of vector registers in the bank
// -----------------------------------------------------------------------------
package vec_pkg;

   localparam int REG_SEL_W = 4;
   localparam int NUM_VREGS = 16;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_LOAD  = 4'd1,
      OP_STORE = 4'd2,
      OP_ADD   = 4'd3,
      OP_SUB   = 4'd4,
      OP_AND   = 4'd5,
      OP_OR    = 4'd6,
      OP_XOR   = 4'd7,
      OP_MOV   = 4'd8
   } vec_op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_EXEC,
      ST_WRITE,
      ST_OUT
   } seq_state_t;

   // Opcodes that are executed by the external ALU.
   function automatic logic is_alu_op(input logic [3:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
   endfunction

   function automatic logic is_legal_op(input logic [3:0] op);
      return op <= OP_MOV;
   endfunction

endpackage

// File: rtl/vec_op_sequencer.sv
// -----------------------------------------------------------------------------
// vec_op_sequencer
// Single-issue controller between the host command path and the
// vec_reg_bank / vec_alu pair. Each accepted instruction is decoded and
// sequenced through READ / EXEC / WRITE / OUT as needed, then retired with a
// one-cycle done pulse and an instr_count increment.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   instr_*                   host instruction (valid/ready handshake)
//   result_valid/ready/data   STORE data returned to the host
//   rb_*                      register bank write port and two read ports
//   alu_op/start/done/result  external ALU control
//   done, busy, instr_count   retire pulse, activity, retired count (wraps)
//   err_illegal, err_timeout  sticky error flags, cleared by err_clr
// -----------------------------------------------------------------------------
module vec_op_sequencer
   import vec_pkg::*;
#(
   parameter int BITS    = 8,
   parameter int N       = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [3:0]           instr_op,
   input  logic [REG_SEL_W-1:0] instr_dst,
   input  logic [REG_SEL_W-1:0] instr_src_a,
   input  logic [REG_SEL_W-1:0] instr_src_b,
   input  logic [BITS-1:0]      instr_data [N-1:0],
   output logic                 result_valid,
   input  logic                 result_ready,
   output logic [BITS-1:0]      result_data [N-1:0],
   output logic [BITS-1:0]      rb_data_in [N-1:0],
   output logic [REG_SEL_W-1:0] rb_in_sel,
   output logic                 rb_write,
   output logic [REG_SEL_W-1:0] rb_out_sel_a,
   output logic [REG_SEL_W-1:0] rb_out_sel_b,
   output logic                 rb_out_en_a,
   output logic                 rb_out_en_b,
   input  logic [BITS-1:0]      rb_out_a [N-1:0],
   input  logic [BITS-1:0]      rb_out_b [N-1:0],
   output logic [3:0]           alu_op,
   output logic                 alu_start,
   input  logic                 alu_done,
   input  logic [BITS-1:0]      alu_result [N-1:0],
   output logic                 done,
   output logic                 busy,
   output logic                 err_illegal,
   output logic                 err_timeout,
   input  logic                 err_clr,
   output logic [15:0]          instr_count
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   seq_state_t             state, state_nxt;
   logic [3:0]             op_q;
   logic [REG_SEL_W-1:0]   dst_q, src_a_q, src_b_q;
   logic [BITS-1:0]        data_q [N-1:0];
   logic [CNT_W-1:0]       tmo_cnt;

   logic accept, retire, illegal_evt, exec_timeout;

   assign accept       = instr_valid && instr_ready;
   assign illegal_evt  = accept && !is_legal_op(instr_op);
   // tmo_cnt holds the index of the current EXEC cycle, so the last allowed
   // cycle is TIMEOUT-1.
   assign exec_timeout = (state == ST_EXEC) && !alu_done &&
                         (tmo_cnt == CNT_W'(TIMEOUT - 1));
   assign retire       = (accept && instr_op == OP_NOP) ||
                         (state == ST_WRITE) ||
                         (state == ST_OUT && result_ready);

   // ---------------------------------------------------------------- state reg
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // --------------------------------------------------------------- next state
   // NOTE: defaulting state_nxt before the case keeps every path assigned, so
   // no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               if (instr_op == OP_LOAD)
                  state_nxt = ST_WRITE;
               else if (instr_op == OP_STORE || instr_op == OP_MOV || is_alu_op(instr_op))
                  state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (is_alu_op(op_q))    state_nxt = ST_EXEC;
            else if (op_q == OP_MOV) state_nxt = ST_WRITE;
            else                     state_nxt = ST_OUT;
         end
         ST_EXEC: begin
            if (alu_done)          state_nxt = ST_WRITE;
            else if (exec_timeout) state_nxt = ST_IDLE;
         end
         ST_WRITE: state_nxt = ST_IDLE;
         ST_OUT:   if (result_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   always_comb begin
      instr_ready  = (state == ST_IDLE) && !rst;
      busy         = (state != ST_IDLE);
      rb_out_sel_a = '0;
      rb_out_sel_b = '0;
      rb_out_en_a  = 1'b0;
      rb_out_en_b  = 1'b0;
      if (state == ST_READ || state == ST_EXEC) begin
         rb_out_sel_a = src_a_q;
         rb_out_en_a  = 1'b1;
         if (is_alu_op(op_q)) begin
            rb_out_sel_b = src_b_q;
            rb_out_en_b  = 1'b1;
         end
      end
      alu_op       = (state == ST_EXEC) ? op_q : 4'd0;
      alu_start    = (state == ST_EXEC) && (tmo_cnt == '0);
      rb_write     = (state == ST_WRITE);
      rb_in_sel    = (state == ST_WRITE) ? dst_q : '0;
      result_valid = (state == ST_OUT);
      for (int i = 0; i < N; i++) begin
         rb_data_in[i]  = (state == ST_WRITE) ? data_q[i] : '0;
         result_data[i] = (state == ST_OUT)   ? data_q[i] : '0;
      end
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q        <= '0;
         dst_q       <= '0;
         src_a_q     <= '0;
         src_b_q     <= '0;
         // NOTE: the data holding registers are a handful of flops, not a RAM,
         // so they are reset like any other state to keep outputs defined.
         for (int i = 0; i < N; i++) data_q[i] <= '0;
         tmo_cnt     <= '0;
         done        <= 1'b0;
         instr_count <= '0;
         err_illegal <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         done <= retire;
         if (retire) instr_count <= instr_count + 16'd1;

         if (accept) begin
            op_q    <= instr_op;
            dst_q   <= instr_dst;
            src_a_q <= instr_src_a;
            src_b_q <= instr_src_b;
            if (instr_op == OP_LOAD) data_q <= instr_data;
         end
         if (state == ST_READ)              data_q <= rb_out_a;
         if (state == ST_EXEC && alu_done)  data_q <= alu_result;

         if (state == ST_EXEC) tmo_cnt <= tmo_cnt + CNT_W'(1);
         else                  tmo_cnt <= '0;

         // A new error event takes priority over a simultaneous clear.
         if (illegal_evt)  err_illegal <= 1'b1;
         else if (err_clr) err_illegal <= 1'b0;
         if (exec_timeout) err_timeout <= 1'b1;
         else if (err_clr) err_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vec_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vec_op_sequencer
// Directed bench for vec_op_sequencer with a behavioural register bank and a
// fixed-latency ALU model. Vector values are written {elem1, elem0}.
// -----------------------------------------------------------------------------
module tb_vec_op_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       instr_valid, instr_ready;
   logic [3:0] instr_op, instr_dst, instr_src_a, instr_src_b;
   logic [7:0] instr_data [1:0];
   logic       result_valid, result_ready;
   logic [7:0] result_data [1:0];
   logic [7:0] rb_data_in [1:0];
   logic [3:0] rb_in_sel;
   logic       rb_write;
   logic [3:0] rb_out_sel_a, rb_out_sel_b;
   logic       rb_out_en_a, rb_out_en_b;
   logic [7:0] rb_out_a [1:0];
   logic [7:0] rb_out_b [1:0];
   logic [3:0] alu_op;
   logic       alu_start, alu_done;
   logic [7:0] alu_result [1:0];
   logic       done, busy, err_illegal, err_timeout, err_clr;
   logic [15:0] instr_count;

   vec_op_sequencer #(.BITS(8), .N(2), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_dst(instr_dst),
      .instr_src_a(instr_src_a), .instr_src_b(instr_src_b),
      .instr_data(instr_data),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_data(result_data),
      .rb_data_in(rb_data_in), .rb_in_sel(rb_in_sel), .rb_write(rb_write),
      .rb_out_sel_a(rb_out_sel_a), .rb_out_sel_b(rb_out_sel_b),
      .rb_out_en_a(rb_out_en_a), .rb_out_en_b(rb_out_en_b),
      .rb_out_a(rb_out_a), .rb_out_b(rb_out_b),
      .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
      .alu_result(alu_result),
      .done(done), .busy(busy),
      .err_illegal(err_illegal), .err_timeout(err_timeout), .err_clr(err_clr),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ----------------------------------------------------------- bank model
   logic [7:0] bank [0:15][1:0];
   always @(posedge clk) if (rb_write) begin
      bank[rb_in_sel][1] <= rb_data_in[1];
      bank[rb_in_sel][0] <= rb_data_in[0];
   end
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         rb_out_a[i] = bank[rb_out_sel_a][i];
         rb_out_b[i] = bank[rb_out_sel_b][i];
      end
   end

   // ------------------------------------------------------------ ALU model
   // alu_done is high two cycles after the alu_start cycle; alu_hang
   // suppresses it entirely.
   logic alu_hang = 1'b0;
   int   alu_cnt;

   function automatic logic [7:0] alu_calc(input logic [3:0] op, input logic [7:0] a, b);
      case (op)
         4'd3:    return a + b;
         4'd4:    return a - b;
         4'd5:    return a & b;
         4'd6:    return a | b;
         4'd7:    return a ^ b;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_cnt <= 0;
         alu_done <= 1'b0;
         alu_result[0] <= 8'h00;
         alu_result[1] <= 8'h00;
      end else begin
         alu_done <= 1'b0;
         if (alu_start && !alu_hang) begin
            alu_cnt <= 1;
            for (int i = 0; i < 2; i++) alu_result[i] <= alu_calc(alu_op, rb_out_a[i], rb_out_b[i]);
         end else if (alu_cnt != 0) begin
            alu_cnt <= alu_cnt - 1;
            if (alu_cnt == 1) alu_done <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------------- monitor
   int          wr_cnt = 0, done_cnt = 0, start_cnt = 0;
   int          done_cyc = 0, start_cyc = 0;
   logic [3:0]  wr_sel, start_op;
   logic [15:0] wr_data;
   always @(negedge clk) begin
      if (rb_write)  begin wr_cnt++; wr_sel = rb_in_sel; wr_data = {rb_data_in[1], rb_data_in[0]}; end
      if (done)      begin done_cnt++; done_cyc = cyc; end
      if (alu_start) begin start_cnt++; start_op = alu_op; start_cyc = cyc; end
   end

   // ------------------------------------------------------------- helpers
   int          acc_cyc;
   logic [15:0] exp_count = 16'd0;

   task automatic issue(input logic [3:0] op, dst, a, b, input logic [15:0] d);
      int n = 0;
      @(negedge clk);
      while (!instr_ready && n < 200) begin @(negedge clk); n++; end
      checks++;
      if (!instr_ready) begin
         errors++;
         $display("FAIL issue_ready: instr_ready=%0b required 1 within 200 cycles", instr_ready);
      end
      instr_valid = 1'b1; instr_op = op; instr_dst = dst;
      instr_src_a = a; instr_src_b = b;
      instr_data[1] = d[15:8]; instr_data[0] = d[7:0];
      @(posedge clk); #1;
      acc_cyc = cyc;
      instr_valid = 1'b0;
   endtask

   task automatic wait_done(input int base, input string name);
      int n = 0;
      while (done_cnt == base && n < 200) begin @(posedge clk); #1; n++; end
      checks++;
      if (done_cnt == base) begin
         errors++;
         $display("FAIL %s_done: done pulses=%0d required %0d", name, done_cnt - base, 1);
      end
   endtask

   // --------------------------------------------------------------- tests
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks += 8;
      if (instr_ready !== 1'b0)  begin errors++; $display("FAIL rst_ready: got %0b required 0", instr_ready); end
      if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %0b required 0", busy); end
      if (rb_write !== 1'b0)     begin errors++; $display("FAIL rst_write: got %0b required 0", rb_write); end
      if (done !== 1'b0)         begin errors++; $display("FAIL rst_done: got %0b required 0", done); end
      if (instr_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d required 0", instr_count); end
      if ({err_illegal, err_timeout} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b required 00", {err_illegal, err_timeout}); end
      if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %0b required 0", result_valid); end
      if ({alu_start, rb_out_en_a, rb_out_en_b} !== 3'b000) begin errors++; $display("FAIL rst_alu_en: got %b required 000", {alu_start, rb_out_en_a, rb_out_en_b}); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b required 1", instr_ready); end
   endtask

   task automatic test_load();
      int wb = wr_cnt, db = done_cnt;
      issue(4'd1, 4'd0, 4'd0, 4'd0, 16'h3C0F);
      wait_done(db, "load");
      exp_count++;
      @(negedge clk);
      checks += 5;
      if (wr_cnt - wb !== 1)      begin errors++; $display("FAIL load_wcnt: got %0d writes required 1", wr_cnt - wb); end
      if (wr_sel !== 4'd0)        begin errors++; $display("FAIL load_sel: got %0d required 0", wr_sel); end
      if (wr_data !== 16'h3C0F)   begin errors++; $display("FAIL load_data: got %h required 3c0f", wr_data); end
      // done in the second cycle after the accept edge
      if (done_cyc - acc_cyc !== 1) begin errors++; $display("FAIL load_lat: got %0d required 2", done_cyc - acc_cyc + 1); end
      if (instr_count !== exp_count) begin errors++; $display("FAIL load_count: got %0d required %0d", instr_count, exp_count); end
   endtask

   task automatic test_alu_add();
      int db, sb, wb;
      db = done_cnt; issue(4'd1, 4'd1, 4'd0, 4'd0, 16'h7EFF); wait_done(db, "load_r1"); exp_count++;
      db = done_cnt; issue(4'd1, 4'd2, 4'd0, 4'd0, 16'h0001); wait_done(db, "load_r2"); exp_count++;
      db = done_cnt; sb = start_cnt; wb = wr_cnt;
      issue(4'd3, 4'd3, 4'd1, 4'd2, 16'h0000);
      wait_done(db, "add");
      exp_count++;
      @(negedge clk);
      checks += 6;
      if (start_cnt - sb !== 1) begin errors++; $display("FAIL add_starts: got %0d required 1", start_cnt - sb); end
      if (start_op !== 4'd3)    begin errors++; $display("FAIL add_op: got %0d required 3", start_op); end
      if (wr_cnt - wb !== 1)    begin errors++; $display("FAIL add_wcnt: got %0d required 1", wr_cnt - wb); end
      if (wr_sel !== 4'd3)      begin errors++; $display("FAIL add_sel: got %0d required 3", wr_sel); end
      if (wr_data !== 16'h7E00) begin errors++; $display("FAIL add_data: got %h required 7e00", wr_data); end
      // READ + 3 EXEC cycles + WRITE, done in the following cycle
      if (done_cyc - acc_cyc !== 5) begin errors++; $display("FAIL add_lat: got %0d required 6", done_cyc - acc_cyc + 1); end
   endtask

   task automatic test_mov();
      int db = done_cnt;
      issue(4'd8, 4'd7, 4'd1, 4'd0, 16'h0000);
      wait_done(db, "mov");
      exp_count++;
      @(negedge clk);
      checks += 3;
      if (wr_sel !== 4'd7)      begin errors++; $display("FAIL mov_sel: got %0d required 7", wr_sel); end
      if (wr_data !== 16'h7EFF) begin errors++; $display("FAIL mov_data: got %h required 7eff", wr_data); end
      if (done_cyc - acc_cyc !== 2) begin errors++; $display("FAIL mov_lat: got %0d required 3", done_cyc - acc_cyc + 1); end
   endtask

   task automatic test_store();
      int db = done_cnt, n = 0;
      result_ready = 1'b0;
      issue(4'd2, 4'd0, 4'd3, 4'd0, 16'h0000);
      while (!result_valid && n < 20) begin @(negedge clk); n++; end
      for (int k = 0; k < 5; k++) begin
         checks += 3;
         if (result_valid !== 1'b1) begin errors++; $display("FAIL store_valid%0d: got %0b required 1", k, result_valid); end
         if ({result_data[1], result_data[0]} !== 16'h7E00) begin errors++; $display("FAIL store_data%0d: got %h required 7e00", k, {result_data[1], result_data[0]}); end
         if (instr_ready !== 1'b0) begin errors++; $display("FAIL store_ready%0d: got %0b required 0", k, instr_ready); end
         @(negedge clk);
      end
      checks++;
      if (done_cnt !== db) begin errors++; $display("FAIL store_early_done: got %0d pulses required 0", done_cnt - db); end
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
      wait_done(db, "store");
      exp_count++;
      @(negedge clk);
      checks += 2;
      if (result_valid !== 1'b0)     begin errors++; $display("FAIL store_release: got %0b required 0", result_valid); end
      if (instr_count !== exp_count) begin errors++; $display("FAIL store_count: got %0d required %0d", instr_count, exp_count); end
   endtask

   task automatic test_timeout();
      int wb = wr_cnt, sb = start_cnt, n = 0;
      alu_hang = 1'b1;
      issue(4'd4, 4'd4, 4'd1, 4'd2, 16'h0000);
      while (!err_timeout && n < 150) begin @(negedge clk); n++; end
      checks += 6;
      if (err_timeout !== 1'b1)      begin errors++; $display("FAIL tmo_flag: got %0b required 1", err_timeout); end
      if (cyc - start_cyc !== 64)    begin errors++; $display("FAIL tmo_cycles: got %0d EXEC cycles required 64", cyc - start_cyc); end
      if (start_cnt - sb !== 1)      begin errors++; $display("FAIL tmo_starts: got %0d required 1", start_cnt - sb); end
      if (wr_cnt !== wb)             begin errors++; $display("FAIL tmo_write: got %0d writes required 0", wr_cnt - wb); end
      if (instr_count !== exp_count) begin errors++; $display("FAIL tmo_count: got %0d required %0d", instr_count, exp_count); end
      if (busy !== 1'b0)             begin errors++; $display("FAIL tmo_busy: got %0b required 0", busy); end
      alu_hang = 1'b0;
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err_timeout !== 1'b0) begin errors++; $display("FAIL tmo_clr: got %0b required 0", err_timeout); end
   endtask

   task automatic test_illegal();
      int wb = wr_cnt, db = done_cnt;
      issue(4'd12, 4'd9, 4'd1, 4'd2, 16'hFFFF);
      repeat (3) @(negedge clk);
      checks += 5;
      if (err_illegal !== 1'b1)      begin errors++; $display("FAIL ill_flag: got %0b required 1", err_illegal); end
      if (wr_cnt !== wb)             begin errors++; $display("FAIL ill_write: got %0d writes required 0", wr_cnt - wb); end
      if (done_cnt !== db)           begin errors++; $display("FAIL ill_done: got %0d pulses required 0", done_cnt - db); end
      if (instr_count !== exp_count) begin errors++; $display("FAIL ill_count: got %0d required %0d", instr_count, exp_count); end
      if (instr_ready !== 1'b1)      begin errors++; $display("FAIL ill_ready: got %0b required 1", instr_ready); end
      issue(4'd0, 4'd0, 4'd0, 4'd0, 16'h0000);
      wait_done(db, "nop");
      exp_count++;
      @(negedge clk);
      checks += 3;
      if (done_cyc - acc_cyc !== 0)  begin errors++; $display("FAIL nop_lat: got %0d required 1", done_cyc - acc_cyc + 1); end
      if (instr_count !== exp_count) begin errors++; $display("FAIL nop_count: got %0d required %0d", instr_count, exp_count); end
      if (err_illegal !== 1'b1)      begin errors++; $display("FAIL ill_sticky: got %0b required 1", err_illegal); end
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      checks++;
      if (err_illegal !== 1'b0) begin errors++; $display("FAIL ill_clr: got %0b required 0", err_illegal); end
   endtask

   task automatic test_reset_mid_exec();
      int wb = wr_cnt, sb = start_cnt, n = 0, db;
      alu_hang = 1'b1;
      issue(4'd5, 4'd5, 4'd1, 4'd2, 16'h0000);
      while (start_cnt == sb && n < 20) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %0b required 1", busy); end
      #1 rst = 1'b1;
      #1;
      checks += 5;
      if ({busy, instr_ready, rb_write} !== 3'b000)   begin errors++; $display("FAIL mid_rst_ctl: got %b required 000", {busy, instr_ready, rb_write}); end
      if ({rb_out_en_a, rb_out_en_b} !== 2'b00)       begin errors++; $display("FAIL mid_rst_en: got %b required 00", {rb_out_en_a, rb_out_en_b}); end
      if ({alu_start, alu_op} !== 5'd0)               begin errors++; $display("FAIL mid_rst_alu: got %h required 0", {alu_start, alu_op}); end
      if (instr_count !== 16'd0)                      begin errors++; $display("FAIL mid_rst_count: got %0d required 0", instr_count); end
      if (done !== 1'b0)                              begin errors++; $display("FAIL mid_rst_done: got %0b required 0", done); end
      @(negedge clk);
      rst = 1'b0;
      alu_hang = 1'b0;
      exp_count = 16'd0;
      checks++;
      if (wr_cnt !== wb) begin errors++; $display("FAIL mid_rst_write: got %0d writes required 0", wr_cnt - wb); end
      db = done_cnt;
      issue(4'd1, 4'd6, 4'd0, 4'd0, 16'hA55A);
      wait_done(db, "post_rst_load");
      exp_count++;
      @(negedge clk);
      checks += 3;
      if (wr_sel !== 4'd6)           begin errors++; $display("FAIL post_rst_sel: got %0d required 6", wr_sel); end
      if (wr_data !== 16'hA55A)      begin errors++; $display("FAIL post_rst_data: got %h required a55a", wr_data); end
      if (instr_count !== exp_count) begin errors++; $display("FAIL post_rst_count: got %0d required %0d", instr_count, exp_count); end
   endtask

   initial begin
      rst = 1'b1; instr_valid = 1'b0; instr_op = 4'd0; instr_dst = 4'd0;
      instr_src_a = 4'd0; instr_src_b = 4'd0;
      instr_data[0] = 8'h00; instr_data[1] = 8'h00;
      result_ready = 1'b0; err_clr = 1'b0;
      test_reset();
      test_load();
      test_alu_add();
      test_mov();
      test_store();
      test_timeout();
      test_illegal();
      test_reset_mid_exec();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
